// File: rtl/contador_modos_pkg.sv
`default_nettype none
// ============================================================================
// Module  : contador_defs (package)
// Brief   : Mode encodings and step constant shared by the mode counter.
// Revision: 1.0 - initial release
// ============================================================================
package contador_defs;

  localparam logic [1:0] MODE_UP3   = 2'b00;
  localparam logic [1:0] MODE_DOWN1 = 2'b01;
  localparam logic [1:0] MODE_UP1   = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  localparam int unsigned C_STEP = 3;

endpackage : contador_defs
`default_nettype wire

// File: rtl/contador_paso.sv
`default_nettype none
// ============================================================================
// Module  : contador_paso
// Brief   : Combinational next-state logic: next value, wrap and load flags.
// Revision: 1.0 - initial release
// ============================================================================
module contador_paso
  import contador_defs::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q_next,
  output logic             wrap,
  output logic             load_flag
);

  // Two extra bits so the +3 carry is visible even for very small WIDTH.
  localparam int c_EXT = WIDTH + 2;
  localparam logic [c_EXT-1:0] c_STEP_EXT  = c_EXT'(C_STEP);
  localparam logic [c_EXT-1:0] c_MODULUS   = c_EXT'(1) << WIDTH;

  logic [c_EXT-1:0] w_sum3;

  assign w_sum3 = c_EXT'(q) + c_STEP_EXT;

  always_comb begin
    q_next    = q;
    wrap      = 1'b0;
    load_flag = 1'b0;
    case (mode)
      MODE_UP3: begin
        q_next = w_sum3[WIDTH-1:0];
        wrap   = (w_sum3 >= c_MODULUS);
      end
      MODE_DOWN1: begin
        q_next = q - WIDTH'(1);
        wrap   = (q == '0);
      end
      MODE_UP1: begin
        q_next = q + WIDTH'(1);
        wrap   = (q == '1);
      end
      default: begin
        q_next    = d;
        load_flag = 1'b1;
      end
    endcase
  end

endmodule : contador_paso
`default_nettype wire

// File: rtl/contador_modos.sv
`default_nettype none
// ============================================================================
// Module  : contador_modos
// Brief   : Four-mode synchronous counter with registered Q, rco and load.
// Revision: 1.0 - initial release
// ============================================================================
module contador_modos
  import contador_defs::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             rco,
  output logic             load
);

  logic [WIDTH-1:0] r_q;
  logic             r_rco;
  logic             r_load;

  logic [WIDTH-1:0] w_q_next;
  logic             w_wrap;
  logic             w_load;

  contador_paso #(
    .WIDTH (WIDTH)
  ) u_paso (
    .q         (r_q),
    .mode      (mode),
    .d         (D),
    .q_next    (w_q_next),
    .wrap      (w_wrap),
    .load_flag (w_load)
  );

  // Flags are pulses: they clear on any edge that does not re-trigger them.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q    <= '0;
      r_rco  <= 1'b0;
      r_load <= 1'b0;
    end else if (!enable) begin
      r_rco  <= 1'b0;
      r_load <= 1'b0;
    end else begin
      r_q    <= w_q_next;
      r_rco  <= w_wrap;
      r_load <= w_load;
    end
  end

  assign Q    = r_q;
  assign rco  = r_rco;
  assign load = r_load;

endmodule : contador_modos
`default_nettype wire
